// File: rtl/alu_issue_wb.sv
// -----------------------------------------------------------------------------
// alu_issue_wb
//
// Two-stage issue/writeback wrapper around an external combinational ALU.
// The block holds a register file of NREGS x DATA_W entries, in which r0 always
// reads as zero. It reads two source operands, or one register and an
// immediate, into a registered execute (EX) latch that drives the ALU. It then
// captures the ALU result and flags into a writeback (WB) latch that uses
// valid/ready backpressure.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   instruction handshake
//   rs, rt, rd            source A, source B, destination register
//   imm, use_imm          immediate operand and B-operand select
//   ctrl, wr_en           ALU control code (passed through), register write
//   alu_a, alu_b,         registered operands and control code to the ALU
//   alu_ctrl
//   alu_out, alu_flags    combinational ALU result and flags
//   res_valid/res_ready   writeback handshake
//   res_data, res_rd      captured result and its destination
//   flags_q               flags of the most recently executed op
//   dbg_raddr/dbg_rdata   combinational debug read port (r0 reads 0)
// -----------------------------------------------------------------------------
module alu_issue_wb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [4:0]        ctrl,
    input  logic              wr_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [2:0]        alu_flags,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_rd,
    output logic [2:0]        flags_q,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] rf [NREGS];

    logic              ex_valid;
    logic [4:0]        ex_rd;
    logic              ex_we;

    logic              ex_adv;
    logic              accept;
    logic              fwd_ok;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // EX moves on whenever WB is empty or is being drained this cycle.
    assign ex_adv   = ex_valid && (!res_valid || res_ready);
    assign in_ready = !ex_valid || ex_adv;
    assign accept   = in_valid && in_ready;

    // The op leaving EX this cycle writes its result at the same edge that a
    // new op samples its operands, so that result is forwarded straight from
    // the ALU output. A stalled EX never forwards, because nothing can be
    // accepted behind it.
    assign fwd_ok = ex_adv && ex_we && (ex_rd != 5'd0);

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        op_a = rf[rs];
        if (rs == 5'd0) begin
            op_a = '0;
        end else if (fwd_ok && (ex_rd == rs)) begin
            op_a = alu_out;
        end

        op_b = imm;
        if (!use_imm) begin
            op_b = rf[rt];
            if (rt == 5'd0) begin
                op_b = '0;
            end else if (fwd_ok && (ex_rd == rt)) begin
                op_b = alu_out;
            end
        end
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf[dbg_raddr];

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            flags_q   <= '0;
        end else begin
            if (accept) begin
                ex_valid <= 1'b1;
                alu_a    <= op_a;
                alu_b    <= op_b;
                alu_ctrl <= ctrl;
                ex_rd    <= rd;
                ex_we    <= wr_en;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end

            if (ex_adv) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
                res_rd    <= ex_rd;
                flags_q   <= alu_flags;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // NOTE: the register file has an explicit reset because software-visible
    // state must read zero after reset. That rules out mapping it onto a
    // plain RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (fwd_ok) begin
            rf[ex_rd] <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_wb
//
// Directed testbench for alu_issue_wb. A small combinational ALU stand-in sits
// beside the DUT:
//   ctrl 0 = add, ctrl 1 = sub, any other ctrl = and
//   flags = {carry out, result bit 2, result == 0}
// All expected values are computed by hand from that definition.
// -----------------------------------------------------------------------------
module tb_alu_issue_wb;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  ctrl;
    logic        wr_en;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic [2:0]  alu_flags;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic [2:0]  flags_q;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int checks   = 0;
    int failures = 0;
    int results  = 0;

    alu_issue_wb #(.DATA_W(32), .NREGS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .use_imm   (use_imm),
        .ctrl      (ctrl),
        .wr_en     (wr_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_rd    (res_rd),
        .flags_q   (flags_q),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in
    always_comb begin
        logic [32:0] sum;
        sum = '0;
        case (alu_ctrl)
            5'd0:    sum = {1'b0, alu_a} + {1'b0, alu_b};
            5'd1:    sum = {1'b0, alu_a} - {1'b0, alu_b};
            default: sum = {1'b0, alu_a & alu_b};
        endcase
        alu_out   = sum[31:0];
        alu_flags = {sum[32], sum[2], (sum[31:0] == 32'd0)};
    end

    // Counts completed writeback handshakes (values sampled before the edge).
    always @(posedge clk) begin
        if (!rst && res_valid && res_ready) results <= results + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, waits (bounded) for in_ready, and returns 1 time unit
    // after the accepting edge with in_valid already low.
    task automatic issue(input logic [4:0] s_a, input logic [4:0] s_b,
                         input logic [4:0] dst, input logic [31:0] im,
                         input logic ui, input logic we, input logic [4:0] c);
        int waited;
        in_valid = 1'b1;
        rs = s_a; rt = s_b; rd = dst; imm = im;
        use_imm = ui; wr_en = we; ctrl = c;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL issue_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        rs = '0; rt = '0; rd = '0; imm = '0; use_imm = 1'b0;
        ctrl = '0; wr_en = 1'b0; dbg_raddr = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== '0) begin
            failures++;
            $display("FAIL reset_alu_regs: got a=%0h b=%0h c=%0h want 0", alu_a, alu_b, alu_ctrl);
        end
        checks++;
        if ({res_data, res_rd, flags_q} !== '0) begin
            failures++;
            $display("FAIL reset_wb_regs: got d=%0h rd=%0h f=%0h want 0", res_data, res_rd, flags_q);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = i[4:0];
            #1;
            checks++;
            if (dbg_rdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_dbg_r%0d: got %0h want 0", i, dbg_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd1, 32'd1, 1'b1, 1'b1, 5'd0);
        issue(5'd0, 5'd0, 5'd2, 32'd2, 1'b1, 1'b1, 5'd0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd1 || res_rd !== 5'd1) begin
            failures++;
            $display("FAIL b2b_res1: got v=%0b d=%0d rd=%0d want v=1 d=1 rd=1", res_valid, res_data, res_rd);
        end
        issue(5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 5'd0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd2 || res_rd !== 5'd2) begin
            failures++;
            $display("FAIL b2b_res2: got v=%0b d=%0d rd=%0d want v=1 d=2 rd=2", res_valid, res_data, res_rd);
        end
        checks++;
        if (alu_a !== 32'd1 || alu_b !== 32'd2) begin
            failures++;
            $display("FAIL b2b_bypass_operands: got a=%0d b=%0d want a=1 b=2", alu_a, alu_b);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd3 || res_rd !== 5'd3) begin
            failures++;
            $display("FAIL b2b_res3: got v=%0b d=%0d rd=%0d want v=1 d=3 rd=3", res_valid, res_data, res_rd);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: res_valid got %0b want 0", res_valid); end
        dbg_raddr = 5'd3;
        #1;
        checks++;
        if (dbg_rdata !== 32'd3) begin failures++; $display("FAIL b2b_dbg_r3: got %0d want 3", dbg_rdata); end
    endtask

    task automatic test_backpressure();
        int start;
        start = results;
        res_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd4, 32'd512, 1'b1, 1'b1, 5'd0);
        issue(5'd0, 5'd0, 5'd5, 32'd1024, 1'b1, 1'b1, 5'd0);
        tick();
        tick();
        res_ready = 1'b0;
        issue(5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 1'b1, 5'd0);
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd1536 || res_rd !== 5'd6) begin
            failures++;
            $display("FAIL bp_r6: got v=%0b d=%0d rd=%0d want v=1 d=1536 rd=6", res_valid, res_data, res_rd);
        end
        issue(5'd0, 5'd0, 5'd8, 32'd7, 1'b1, 1'b1, 5'd0);
        // r9 = r6 + 1 waits behind the full pipeline.
        in_valid = 1'b1; rs = 5'd6; rd = 5'd9; imm = 32'd1;
        use_imm = 1'b1; wr_en = 1'b1; ctrl = 5'd0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'd1536) begin
                failures++;
                $display("FAIL bp_hold_c%0d: got rdy=%0b v=%0b d=%0d want rdy=0 v=1 d=1536",
                         c, in_ready, res_valid, res_data);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (res_data !== 32'd7 || res_rd !== 5'd8) begin
            failures++;
            $display("FAIL bp_r8: got d=%0d rd=%0d want d=7 rd=8", res_data, res_rd);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd1537 || res_rd !== 5'd9) begin
            failures++;
            $display("FAIL bp_r9: got v=%0b d=%0d rd=%0d want v=1 d=1537 rd=9", res_valid, res_data, res_rd);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || results - start !== 5) begin
            failures++;
            $display("FAIL bp_count: got v=%0b n=%0d want v=0 n=5", res_valid, results - start);
        end
    endtask

    task automatic test_r0_write();
        res_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd0, 32'd150, 1'b1, 1'b1, 5'd0);
        issue(5'd0, 5'd0, 5'd7, 32'd4, 1'b1, 1'b1, 5'd0);
        checks++;
        if (res_data !== 32'd150 || res_rd !== 5'd0) begin
            failures++;
            $display("FAIL r0_result: got d=%0d rd=%0d want d=150 rd=0", res_data, res_rd);
        end
        tick();
        checks++;
        if (res_data !== 32'd4 || res_rd !== 5'd7) begin
            failures++;
            $display("FAIL r0_next: got d=%0d rd=%0d want d=4 rd=7", res_data, res_rd);
        end
        tick();
        dbg_raddr = 5'd0;
        #1;
        checks++;
        if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL r0_dbg: got %0d want 0", dbg_rdata); end
    endtask

    task automatic test_no_write();
        res_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd1, 32'd1243, 1'b1, 1'b1, 5'd0);
        tick();
        checks++;
        if (flags_q !== 3'b000) begin failures++; $display("FAIL nowr_setup_flags: got %b want 000", flags_q); end
        tick();
        issue(5'd1, 5'd0, 5'd1, 32'd10, 1'b1, 1'b0, 5'd0);
        tick();
        checks++;
        if (res_data !== 32'd1253 || flags_q !== 3'b010) begin
            failures++;
            $display("FAIL nowr_result: got d=%0d f=%b want d=1253 f=010", res_data, flags_q);
        end
        tick();
        dbg_raddr = 5'd1;
        #1;
        checks++;
        if (dbg_rdata !== 32'd1243) begin failures++; $display("FAIL nowr_dbg_r1: got %0d want 1243", dbg_rdata); end
    endtask

    task automatic test_reset_inflight();
        res_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd10, 32'd100, 1'b1, 1'b1, 5'd0);
        res_ready = 1'b0;
        issue(5'd0, 5'd0, 5'd11, 32'd55, 1'b1, 1'b1, 5'd0);
        checks++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0 || flags_q !== 3'b010) begin
            failures++;
            $display("FAIL rstf_full: got v=%0b rdy=%0b f=%b want v=1 rdy=0 f=010", res_valid, in_ready, flags_q);
        end
        // Reset while an accept and a drain are also requested.
        rst = 1'b1; res_ready = 1'b1;
        in_valid = 1'b1; rs = 5'd0; rd = 5'd12; imm = 32'd9; use_imm = 1'b1; wr_en = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || flags_q !== 3'b000 || res_data !== 32'd0) begin
            failures++;
            $display("FAIL rstf_state: got v=%0b rdy=%0b f=%b d=%0d want v=0 rdy=1 f=000 d=0",
                     res_valid, in_ready, flags_q, res_data);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL rstf_dropped: res_valid got %0b want 0", res_valid); end
        for (int r = 10; r <= 12; r++) begin
            dbg_raddr = r[4:0];
            #1;
            checks++;
            if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL rstf_dbg_r%0d: got %0d want 0", r, dbg_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_r0_write();
        test_no_write();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
